sqrt_stage2: RTL
================

# sqrt_stage2

Second stage of the iterative integer square-root datapath, directly downstream of the Stage1 register bank. It reads Stage1's registered state: operand, the two ping-pong square registers, the write-select flag and the current root. It compares the active square against the operand and computes the next root and square, feeding them back into Stage1's inputs. It owns the iteration FSM and the host start/result handshake, and returns floor(sqrt(x)) for a 16-bit operand x.

## Interface
- No parameters; widths are fixed: operand 16, square 17, root 8.
- clk  in  1  sole clock; rising edge.
- rst  in  1  asynchronous reset, active-high.
- start_i  in  1  host request; accepted when start_i & ready_o.
- abort_i  in  1  abandons a running computation.
- ack_i  in  1  host consumes the result; completes when valid_o & ack_i.
- input_s_i  in  16  operand x, from Stage1 input_o.
- square1_s_i  in  17  from Stage1 square1_o.
- square2_s_i  in  17  from Stage1 square2_o.
- wr_square_s_i  in  1  from Stage1 wr_square_s_o; 1 selects square2, 0 selects square1.
- root_s_i  in  8  from Stage1 root_o.
- wr_input_o  out  1  drives Stage1 wr_input_i.
- en_pipe_o  out  1  drives Stage1 en_pipe_i.
- wr_square_o  out  1  drives both Stage1 wr_square_i and wr_square_s_i.
- square_fb_o  out  17  drives both Stage1 square1_i and square2_i.
- root_fb_o  out  8  drives Stage1 root_i.
- ready_o  out  1  high in IDLE.
- valid_o  out  1  result available.
- result_o  out  8  floor(sqrt(x)).
- iter_o  out  9  number of RUN cycles used by the last computation.

## Operation
- Invariant during RUN: root_s_i = r and sq_sel = (r+1)^2.
  - sq_sel = wr_square_s_i ? square2_s_i : square1_s_i.
- States and transitions:
  - IDLE → RUN on start_i.
  - RUN → DONE when sq_sel > input_s_i.
  - RUN → IDLE on abort_i. Abort has priority over termination.
  - DONE → IDLE on ack_i.
- Accept cycle (IDLE & start_i), all combinational:
  - wr_input_o=1, en_pipe_o=1, root_fb_o=0, square_fb_o=1, wr_square_o=0.
  - The host holds x on Stage1 input_i during this cycle.
  - Clear the iteration counter.
- RUN, continue case (sq_sel ≤ input_s_i):
  - en_pipe_o=1.
  - root_fb_o = r+1.
  - square_fb_o = sq_sel + 2r + 3, computed in 17 bits. Its maximum is 65536 (r=254), so it never overflows.
  - wr_square_o = ~wr_square_s_i, so the ping-pong register alternates.
  - iter counter +1.
- RUN, terminate case (sq_sel > input_s_i):
  - Register result_o ← r; register iter_o ← counter+1.
  - en_pipe_o=0.
- Hold behaviour, in every cycle that is neither an accept cycle nor a RUN-continue cycle (IDLE without start, DONE, and the RUN-terminate or RUN-abort cycle):
  - en_pipe_o=0, wr_input_o=0.
  - wr_square_o = wr_square_s_i and square_fb_o = sq_sel, so the Stage1 square register rewrites itself and holds its value.
  - root_fb_o = root_s_i.
- valid_o=1 only in DONE; result_o and iter_o are stable while valid_o is high.
- start_i is ignored outside IDLE; ack_i is ignored outside DONE.
- When abort_i is taken in RUN: result_o and iter_o keep their previous values and valid_o stays 0.
- Reset values:
  - state IDLE, ready_o=1, valid_o=0, result_o=0, iter_o=0.
  - All combinational outputs follow the IDLE hold rules.
- Reset mid-RUN or mid-DONE returns to IDLE immediately; no result is produced. Stage1 is cleared by the same reset network.

## Timing
- Start is sampled at the edge ending cycle 0.
- Stage1 holds x, r=0 and square1=1 from cycle 1.
- RUN occupies cycles 1 … r+1, i.e. floor(sqrt(x))+1 cycles.
- valid_o rises in cycle r+2 and is held until ack.
- The cycle after the ack edge is IDLE with ready_o=1. Start can be accepted in that same cycle, which gives a 1-cycle turnaround.
- Worst case x=65535: 256 RUN cycles, valid_o in cycle 257, iter_o=256.
- No combinational path from start_i, ack_i or abort_i to valid_o or result_o.

## Test plan
- Reset, then x=0 → valid_o in cycle 2, result_o=0, iter_o=1. ready_o=1 and valid_o=0 during reset.
- x=144 and x=143 → result_o=12 / 11, iter_o=13 / 12. wr_square_o alternates every RUN cycle and Stage1 square values follow 1, 4, 9, ….
- x=65535 → result_o=255, iter_o=256, valid_o in cycle 257; peak square_fb_o is 65536 with no wrap.
- Hold valid_o for 5 cycles without ack_i, pulsing start_i meanwhile → outputs unchanged, start ignored. Assert ack_i together with a new start on the following cycle (x=4) → back-to-back accept, result_o=2.
- Assert abort_i in RUN cycle 3 of x=10000 → IDLE next cycle, valid_o never rises, result_o keeps the prior value. A subsequent x=9 returns 3.
- Assert rst mid-RUN → immediate IDLE, ready_o=1, valid_o=0, result_o=0. The next computation (x=50) returns 7.

Source files
------------

// File: rtl/sqrt_stage2.sv
// sqrt_stage2: Stage2 of the iterative integer sqrt (compare, next root/square feedback, FSM, host start/abort/ack handshake)
module sqrt_stage2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        ack_i,
  input  logic [15:0] input_s_i,
  input  logic [16:0] square1_s_i,
  input  logic [16:0] square2_s_i,
  input  logic        wr_square_s_i,
  input  logic [7:0]  root_s_i,
  output logic        wr_input_o,
  output logic        en_pipe_o,
  output logic        wr_square_o,
  output logic [16:0] square_fb_o,
  output logic [7:0]  root_fb_o,
  output logic        ready_o,
  output logic        valid_o,
  output logic [7:0]  result_o,
  output logic [8:0]  iter_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [8:0] cnt;
  logic [16:0] sq_sel;
  logic term, accept, cont;
  assign sq_sel = wr_square_s_i ? square2_s_i : square1_s_i;
  assign term = sq_sel > {1'b0, input_s_i};
  assign accept = state == IDLE && start_i;
  assign cont = state == RUN && !abort_i && !term;
  assign ready_o = state == IDLE;
  assign valid_o = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start_i ? RUN : IDLE;
      RUN:  state_n = abort_i ? IDLE : term ? DONE : RUN;
      DONE: state_n = ack_i ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
    wr_input_o = accept;
    en_pipe_o = accept || cont;
    root_fb_o = accept ? 8'd0 : cont ? root_s_i + 8'd1 : root_s_i;
    square_fb_o = accept ? 17'd1 : cont ? sq_sel + {8'd0, root_s_i, 1'b0} + 17'd3 : sq_sel;
    wr_square_o = accept ? 1'b0 : cont ? !wr_square_s_i : wr_square_s_i;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      result_o <= '0;
      iter_o <= '0;
    end else begin
      state <= state_n;
      cnt <= accept ? 9'd0 : cont ? cnt + 9'd1 : cnt;
      if (state == RUN && !abort_i && term) begin
        result_o <= root_s_i;
        iter_o <= cnt + 9'd1;
      end
    end
  end
endmodule
